// File: rtl/spi_cfg_pkg.sv
// ============================================================================
// spi_cfg_pkg
// Shared types and constants for the PWM configuration SPI sequencer:
// FSM state encoding, frame field positions and register addresses.
// Revision: 1.0
// ============================================================================
`default_nettype none

package spi_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam int FRAME_W  = 16;
  localparam int CMD_W    = FRAME_W - 1;   // address + data, write bit implied
  localparam int RW_BIT   = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  localparam int BIT_CNT_W = 5;
  localparam int DIV_CNT_W = 8;

  // PWM peripheral register map
  localparam logic [6:0] ADDR_EN_REG_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_REG_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_REG_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_REG_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY_CYCLE  = 7'h04;

  // Assemble a write frame: write flag, address, data (MSB sent first)
  function automatic logic [FRAME_W-1:0] build_frame(input logic [6:0] addr,
                                                     input logic [7:0] data);
    logic [FRAME_W-1:0] f;
    f                     = '0;
    f[RW_BIT]             = 1'b1;
    f[ADDR_MSB:ADDR_LSB]  = addr;
    f[DATA_MSB:DATA_LSB]  = data;
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_cmd_fifo.sv
// ============================================================================
// spi_cmd_fifo
// Synchronous command FIFO with registered occupancy level. Pointers wrap
// naturally because the depth is a power of two.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 15,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Next pointer and level; simultaneous push and pop keep the level
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents need no reset since the level gates reads
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/spi_cfg_sequencer.sv
// ============================================================================
// spi_cfg_sequencer
// Buffers register-write commands and serialises each as a 16-bit SPI
// mode-0 write frame with a slow SCLK suited to synchronising receivers.
// All pin outputs are registered from the current FSM state, so they trail
// the state register by one cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_cfg_sequencer
  import spi_cfg_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               req_valid,
  input  logic [6:0]                         req_addr,
  input  logic [7:0]                         req_data,
  output logic                               req_ready,
  output logic                               SCLK,
  output logic                               COPI,
  output logic                               nCS,
  output logic                               busy,
  output logic                               frame_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [DIV_CNT_W-1:0] DIV_RELOAD = DIV_CNT_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0]     GAP_RELOAD = GAP_W'(GAP_CYCLES - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT   = BIT_CNT_W'(FRAME_W);

  state_e                 state_q, state_d;
  logic [DIV_CNT_W-1:0]   div_q, div_d;
  logic [BIT_CNT_W-1:0]   bit_q, bit_d;
  logic                   phase_q, phase_d;   // 0: SCLK high half, 1: low half
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [FRAME_W-1:0]     shreg_q, shreg_d;
  logic                   sclk_q, sclk_d;
  logic                   copi_q, copi_d;
  logic                   ncs_q, ncs_d;
  logic                   done_q, done_d;

  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CMD_W-1:0]       fifo_head;
  logic [LVL_W-1:0]       fifo_lvl;

  spi_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_valid),
    .push_data ({req_addr, req_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_lvl)
  );

  assign req_ready  = ~fifo_full;
  assign fifo_level = fifo_lvl;
  assign busy       = (state_q != ST_IDLE) | ~fifo_empty;
  assign SCLK       = sclk_q;
  assign COPI       = copi_q;
  assign nCS        = ncs_q;
  assign frame_done = done_q;

  // Next-state, counters, shifter and the pin values for the current state
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    phase_d  = phase_q;
    gap_d    = gap_q;
    shreg_d  = shreg_q;
    fifo_pop = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = build_frame(fifo_head[CMD_W-1:8], fifo_head[7:0]);
          div_d    = DIV_RELOAD;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (div_q == '0) begin
          div_d   = DIV_RELOAD;
          phase_d = 1'b0;
          bit_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          div_d = div_q - DIV_CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (div_q != '0) begin
          div_d = div_q - DIV_CNT_W'(1);
        end else begin
          div_d = DIV_RELOAD;
          if (!phase_q) begin
            // Entering the low half: present the next bit (zero after bit 0)
            phase_d = 1'b1;
            shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
            bit_d   = bit_q + BIT_CNT_W'(1);
          end else if (bit_q == LAST_BIT) begin
            phase_d = 1'b0;
            gap_d   = GAP_RELOAD;
            state_d = ST_GAP;
          end else begin
            phase_d = 1'b0;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    ncs_d  = !((state_q == ST_SETUP) || (state_q == ST_SHIFT));
    sclk_d = (state_q == ST_SHIFT) && !phase_q;
    copi_d = ((state_q == ST_SETUP) || (state_q == ST_SHIFT)) ? shreg_q[FRAME_W-1] : 1'b0;
    done_d = (state_q == ST_GAP) && (gap_q == GAP_RELOAD);
  end

  // State, counters and registered pin outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      gap_q   <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      ncs_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      gap_q   <= gap_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      ncs_q   <= ncs_d;
      done_q  <= done_d;
    end
  end

endmodule

`default_nettype wire
